// File: rtl/d_cache_responder.sv
// d_cache_responder: data-side responder behind the load/store queue dispatch port.
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines,
// store-forward bypass for loads, and line refill from memory.
// Optional build macro DC_STATS_EN adds hit/miss counters (hit_count, miss_count).
module d_cache_responder #(
    parameter int ADDR_WIDTH      = 26,
    parameter int DATA_WIDTH      = 32,
    parameter int INDEX_WIDTH     = 4,
    parameter int LSQ_INDEX_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic                       req_bypass,
    input  logic [DATA_WIDTH-1:0]      req_bypass_data,
    input  logic [LSQ_INDEX_WIDTH-1:0] req_index,
    output logic                       dc_miss,
    output logic                       resp_valid,
    output logic                       resp_is_load,
    output logic [LSQ_INDEX_WIDTH-1:0] resp_index,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic                       mem_req_valid,
    output logic                       mem_req_write,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr,
    output logic [DATA_WIDTH-1:0]      mem_req_data,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_resp_data
`ifdef DC_STATS_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, STORE_REQ, REFILL_REQ, REFILL_DATA} state_t;

    state_t state, state_n;

    logic [LINES-1:0]      line_valid;
    logic [TAG_W-1:0]      line_tag  [LINES];
    logic [DATA_WIDTH-1:0] line_data [LINES][4];

    logic [1:0]                 beat;
    logic [LSQ_INDEX_WIDTH-1:0] st_index;

    // Request address decode
    logic [1:0]             req_off;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0]       req_tag;
    assign req_off = req_addr[1:0];
    assign req_idx = req_addr[INDEX_WIDTH+1:2];
    assign req_tag = req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];

    // The refill target comes from mem_req_addr, which holds the line base
    // untouched until the next memory request is issued.
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    assign fill_idx = mem_req_addr[INDEX_WIDTH+1:2];
    assign fill_tag = mem_req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];

    logic idle, hit, load_miss, load_accept, store_accept, fill_beat, fill_last;
    assign idle         = (state == IDLE);
    assign hit          = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign load_miss    = idle && req_valid && !req_write && !req_bypass && !hit;
    assign load_accept  = idle && req_valid && !req_write && (req_bypass || hit);
    assign store_accept = idle && req_valid && req_write;
    assign fill_beat    = (state == REFILL_DATA) && mem_resp_valid;
    assign fill_last    = fill_beat && (beat == 2'd3);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and queue hold signal
    always_comb begin
        state_n = state;
        dc_miss = !idle || load_miss;
        case (state)
            IDLE: begin
                if (store_accept)   state_n = STORE_REQ;
                else if (load_miss) state_n = REFILL_REQ;
            end
            STORE_REQ:   if (mem_req_ready) state_n = IDLE;
            REFILL_REQ:  if (mem_req_ready) state_n = REFILL_DATA;
            REFILL_DATA: if (fill_last)     state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end

    // Registered response, memory request and beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid    <= 1'b0;
            resp_is_load  <= 1'b0;
            resp_index    <= '0;
            resp_data     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            beat          <= 2'd0;
            st_index      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_accept) begin
                        resp_valid   <= 1'b1;
                        resp_is_load <= 1'b1;
                        resp_index   <= req_index;
                        resp_data    <= req_bypass ? req_bypass_data
                                                   : line_data[req_idx][req_off];
                    end else if (store_accept) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= req_addr;
                        mem_req_data  <= req_data;
                        st_index      <= req_index;
                    end else if (load_miss) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_req_data  <= '0;
                    end
                end
                STORE_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_is_load  <= 1'b0;
                        resp_index    <= st_index;
                        resp_data     <= '0;
                    end
                end
                REFILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= 2'd0;
                    end
                end
                REFILL_DATA: begin
                    if (mem_resp_valid) beat <= beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Line valid bits: cleared by reset, set when the last refill beat lands
    always_ff @(posedge clk) begin
        if (!rst_n)         line_valid <= '0;
        else if (fill_last) line_valid[fill_idx] <= 1'b1;
    end

    // Line data/tag: store-hit update and refill writes (valid gates their use)
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (store_accept && hit)
                line_data[req_idx][req_off] <= req_data;
            if (fill_beat)
                line_data[fill_idx][beat] <= mem_resp_data;
            if (fill_last)
                line_tag[fill_idx] <= fill_tag;
        end
    end

`ifdef DC_STATS_EN
    // Hit counter on accepted non-bypass load hits, miss counter on refill start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (load_accept && !req_bypass) hit_count  <= hit_count + 32'd1;
            if (load_miss)                  miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_cache_responder.sv
// Scoreboard bench for d_cache_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares each response pulse.
module tb_d_cache_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_bypass;
    logic [25:0] req_addr;
    logic [31:0] req_data, req_bypass_data;
    logic [2:0]  req_index;
    logic        dc_miss, resp_valid, resp_is_load;
    logic [2:0]  resp_index;
    logic [31:0] resp_data;
    logic        mem_req_valid, mem_req_write;
    logic [25:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef DC_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    d_cache_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_data(req_data), .req_bypass(req_bypass),
        .req_bypass_data(req_bypass_data), .req_index(req_index),
        .dc_miss(dc_miss), .resp_valid(resp_valid), .resp_is_load(resp_is_load),
        .resp_index(resp_index), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
`ifdef DC_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   nchk = 0;
    int   nerr = 0;

    // Monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            nchk++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL resp_unexpected: got load=%0b idx=%0d data=%h, expected none",
                         resp_is_load, resp_index, resp_data);
            end else begin
                e = sb.pop_front();
                if (resp_is_load !== e.is_load || resp_index !== e.idx || resp_data !== e.data) begin
                    nerr++;
                    $display("FAIL resp: got load=%0b idx=%0d data=%h, expected load=%0b idx=%0d data=%h",
                             resp_is_load, resp_index, resp_data, e.is_load, e.idx, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_load, input logic [2:0] idx, input logic [31:0] data);
        exp_t x;
        x.is_load = is_load;
        x.idx     = idx;
        x.data    = data;
        sb.push_back(x);
    endtask

    task automatic send_req(input logic wr, input logic [25:0] addr, input logic [31:0] data,
                            input logic byp, input logic [31:0] bdata, input logic [2:0] idx);
        req_valid       = 1'b1;
        req_write       = wr;
        req_addr        = addr;
        req_data        = data;
        req_bypass      = byp;
        req_bypass_data = bdata;
        req_index       = idx;
        #1;
    endtask

    // Presented load is expected to be accepted now and answered next cycle
    task automatic accept_load(input logic [2:0] idx, input logic [31:0] data);
        chk("load_dc_miss", dc_miss, 0);
        push(1'b1, idx, data);
        tick();
        req_valid = 1'b0;
        chk("load_latency", resp_valid, 1);
    endtask

    // Presented load is expected to miss; run the full refill handshake
    task automatic refill(input logic [25:0] base, input logic [31:0] d0);
        chk("miss_dc_miss", dc_miss, 1);
        tick();
        chk("refill_req_valid", mem_req_valid, 1);
        chk("refill_req_write", mem_req_write, 0);
        chk("refill_req_addr", mem_req_addr, base);
        chk("refill_dc_miss", dc_miss, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("refill_req_drop", mem_req_valid, 0);
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = d0 + b;
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    // Store: accept, hold memory request for 'stall' cycles, then ack
    task automatic store(input logic [25:0] addr, input logic [31:0] data,
                         input logic [2:0] idx, input int stall);
        send_req(1'b1, addr, data, 1'b0, 32'h0, idx);
        chk("store_dc_miss", dc_miss, 0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            chk("store_req_valid", mem_req_valid, 1);
            chk("store_req_write", mem_req_write, 1);
            chk("store_req_addr", mem_req_addr, addr);
            chk("store_req_data", mem_req_data, data);
            chk("store_hold_dc_miss", dc_miss, 1);
            if (i < stall) tick();
        end
        mem_req_ready = 1'b1;
        push(1'b0, idx, 32'h0);
        tick();
        mem_req_ready = 1'b0;
        chk("store_ack_latency", resp_valid, 1);
        chk("store_req_drop", mem_req_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        req_bypass = 1'b0; req_bypass_data = '0; req_index = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) tick();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_is_load", resp_is_load, 0);
        chk("rst_resp_index", resp_index, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_dc_miss", dc_miss, 0);

        // Cold miss at 0x40, refill A0..A3, held request then hits
        send_req(1'b0, 26'h40, 32'h0, 1'b0, 32'h0, 3'd2);
        refill(26'h40, 32'hA0);
        accept_load(3'd2, 32'hA0);
        tick();
        chk("resp_single_pulse", resp_valid, 0);
`ifdef DC_STATS_EN
        chk("miss_count_1", miss_count, 1);
        chk("hit_count_1", hit_count, 1);
`endif

        // Bypass load on a cold address: no memory traffic
        send_req(1'b0, 26'h200, 32'h0, 1'b1, 32'hDEAD, 3'd5);
        accept_load(3'd5, 32'hDEAD);
        chk("bypass_no_mem", mem_req_valid, 0);

        // Store hit updates cache, subsequent load returns it
        store(26'h41, 32'h1234, 3'd1, 0);
        send_req(1'b0, 26'h41, 32'h0, 1'b0, 32'h0, 3'd3);
        accept_load(3'd3, 32'h1234);

        // Store with memory back-pressure for 5 cycles
        store(26'h42, 32'h55, 3'd4, 5);
        send_req(1'b0, 26'h42, 32'h0, 1'b0, 32'h0, 3'd6);
        accept_load(3'd6, 32'h55);

        // Reset after 2 refill beats, then stray beats are ignored
        send_req(1'b0, 26'hC0, 32'h0, 1'b0, 32'h0, 3'd6);
        chk("c0_dc_miss", dc_miss, 1);
        tick();
        chk("c0_req_addr", mem_req_addr, 26'hC0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hE0 + b;
            tick();
        end
        mem_resp_valid = 1'b0;
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_mem_req_valid", mem_req_valid, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hF0 + b;
            tick();
        end
        mem_resp_valid = 1'b0;
        #1;
        chk("stray_idle_dc_miss", dc_miss, 0);
        chk("stray_no_resp", resp_valid, 0);
        send_req(1'b0, 26'h40, 32'h0, 1'b0, 32'h0, 3'd2);
        refill(26'h40, 32'hB0);
        accept_load(3'd2, 32'hB0);
`ifdef DC_STATS_EN
        chk("miss_count_after_rst", miss_count, 1);
        chk("hit_count_after_rst", hit_count, 1);
`endif

        // Store to uncached 0x80 does not allocate; the load refills
        store(26'h80, 32'h77, 3'd0, 0);
        send_req(1'b0, 26'h80, 32'h0, 1'b0, 32'h0, 3'd7);
        refill(26'h80, 32'hC0);
        accept_load(3'd7, 32'hC0);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
